// File: rtl/sdram_responder.sv
// SDR SDRAM device responder: decodes controller commands, tracks open rows per bank, serves data from on-chip RAM.
// Latency: writes land at the WR edge; read data is driven in the cycle ending at edge RD+CL (CL = 2 or 3).
// Backpressure: none; protocol misuse is reported through sticky ERR/ERR_CODE, never by stalling.
module sdram_responder #(
  parameter int ROW_IDX_W = 4,
  parameter int COL_IDX_W = 4,
  parameter int TRCD      = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        CKE,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic        WEn,
  input  logic [12:0] ADDR,
  input  logic [1:0]  BA,
  inout  wire  [31:0] DQ,
  input  logic [3:0]  DQM,
  output logic        ERR,
  output logic [3:0]  ERR_CODE,
  output logic [15:0] REF_CNT
);

  localparam int IDX_W     = 2 + ROW_IDX_W + COL_IDX_W;
  localparam int MEM_DEPTH = 2 ** IDX_W;
  localparam int RCD_W     = (TRCD < 1) ? 1 : $clog2(TRCD + 1);
  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(TRCD);

  logic [31:0]      mem [MEM_DEPTH];
  logic [3:0]       active;
  logic [12:0]      open_row [4];
  logic [RCD_W-1:0] rcd_cnt [4];
  logic [2:0]       cl;

  // Read pipeline: stage 1 holds CL=3 reads, stage 0 feeds the output drive register.
  logic [1:0]       pipe_vld;
  logic [31:0]      pipe_dat [2];
  logic             drv_en;
  logic [31:0]      drv_dat;

  logic cmd_lmr, cmd_pre, cmd_ref, cmd_act, cmd_wr, cmd_rd, cmd_ill;
  logic bank_open, rcd_busy, lmr_ok, conflict, wr_go, rd_go, cancel;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      rd_masked;
  logic [3:0]       viol;
  logic             unused_ok;

  // Command decode; CKE low or deselect is a NOP.
  always_comb begin
    cmd_lmr = 1'b0;
    cmd_pre = 1'b0;
    cmd_ref = 1'b0;
    cmd_act = 1'b0;
    cmd_wr  = 1'b0;
    cmd_rd  = 1'b0;
    cmd_ill = 1'b0;
    if (CKE && !CSn) begin
      case ({RASn, CASn, WEn})
        3'b111:  ;
        3'b000:  cmd_lmr = 1'b1;
        3'b010:  cmd_pre = 1'b1;
        3'b001:  cmd_ref = 1'b1;
        3'b011:  cmd_act = 1'b1;
        3'b100:  cmd_wr  = 1'b1;
        3'b101:  cmd_rd  = 1'b1;
        default: cmd_ill = 1'b1;
      endcase
    end
  end

  assign bank_open = active[BA];
  // Counter holds TRCD at the first edge after ACT, so a value above 1 means fewer than TRCD cycles have elapsed.
  assign rcd_busy  = rcd_cnt[BA] > RCD_W'(1);
  assign lmr_ok    = ((ADDR[6:4] == 3'd2) || (ADDR[6:4] == 3'd3)) && (ADDR[2:0] == 3'd0);
  assign idx       = {BA, open_row[BA][ROW_IDX_W-1:0], ADDR[COL_IDX_W-1:0]};
  assign rd_word   = mem[idx];
  assign conflict  = drv_en | pipe_vld[0];
  assign wr_go     = cmd_wr & bank_open;
  assign rd_go     = cmd_rd & bank_open;
  assign cancel    = wr_go & pipe_vld[0];
  assign DQ        = drv_en ? drv_dat : 32'bz;
  assign unused_ok = ^{open_row[0][12:ROW_IDX_W], open_row[1][12:ROW_IDX_W],
                       open_row[2][12:ROW_IDX_W], open_row[3][12:ROW_IDX_W]};

  // Masked bytes of read data are returned as zero.
  always_comb begin
    rd_masked = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (DQM[i]) rd_masked[8*i +: 8] = 8'h00;
    end
  end

  // Violation code for this command; 0 means the command is legal.
  always_comb begin
    viol = 4'd0;
    if (cmd_ill) viol = 4'd1;
    else if (cmd_lmr) begin
      if (|active) viol = 4'd3;
      else if (!lmr_ok) viol = 4'd2;
    end
    else if (cmd_ref && (|active)) viol = 4'd4;
    else if (cmd_wr || cmd_rd) begin
      if (!bank_open) viol = 4'd5;
      else if (rcd_busy) viol = 4'd6;
      else if (cmd_wr && conflict) viol = 4'd7;
    end
  end

  // Storage write with per-byte masking; RAM contents survive reset.
  always_ff @(posedge HCLK) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (!DQM[i]) mem[idx][8*i +: 8] <= DQ[8*i +: 8];
      end
    end
  end

  // Bank open/close state and ACT-to-access timers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      active <= '0;
      for (int b = 0; b < 4; b++) begin
        open_row[b] <= '0;
        rcd_cnt[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (rcd_cnt[b] != '0) rcd_cnt[b] <= rcd_cnt[b] - RCD_W'(1);
      end
      if (cmd_act) begin
        active[BA]   <= 1'b1;
        open_row[BA] <= ADDR;
        rcd_cnt[BA]  <= RCD_LOAD;
      end
      if (cmd_pre) begin
        if (ADDR[10]) active <= '0;
        else active[BA] <= 1'b0;
      end
      if ((wr_go || rd_go) && ADDR[10]) active[BA] <= 1'b0;
    end
  end

  // Mode register, refresh counter and first-error capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cl       <= 3'd3;
      REF_CNT  <= '0;
      ERR      <= 1'b0;
      ERR_CODE <= '0;
    end else begin
      if (cmd_lmr && !(|active) && lmr_ok) cl <= ADDR[6:4];
      if (cmd_ref && (REF_CNT != 16'hFFFF)) REF_CNT <= REF_CNT + 16'd1;
      if ((viol != 4'd0) && !ERR) begin
        ERR      <= 1'b1;
        ERR_CODE <= viol;
      end
    end
  end

  // Read data captured at the RD edge and delayed so the drive lands in the cycle ending at RD+CL.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pipe_vld    <= '0;
      pipe_dat[0] <= '0;
      pipe_dat[1] <= '0;
      drv_en      <= 1'b0;
      drv_dat     <= '0;
    end else begin
      drv_en      <= pipe_vld[0] & ~cancel;
      drv_dat     <= pipe_dat[0];
      pipe_vld[0] <= pipe_vld[1];
      pipe_dat[0] <= pipe_dat[1];
      pipe_vld[1] <= 1'b0;
      if (rd_go) begin
        if (cl == 3'd2) begin
          pipe_vld[0] <= 1'b1;
          pipe_dat[0] <= rd_masked;
        end else begin
          pipe_vld[1] <= 1'b1;
          pipe_dat[1] <= rd_masked;
        end
      end
    end
  end

endmodule
